// File: rtl/vit_pkg.sv
// Shared widths, state-index type and output-stage FSM encoding for the
// 4-state register-exchange Viterbi decoder.
package vit_pkg;
    localparam int PM_W     = 7;
    localparam int SP_W     = 8;
    localparam int N_STATES = 4;

    typedef logic [1:0] state_idx_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;
endpackage

// File: rtl/vit_min4.sv
// Combinational 4-way unsigned minimum; returns index and value, lowest index
// wins ties. Shared with the ACS normalization path.
module vit_min4
    import vit_pkg::*;
(
    input  logic [PM_W-1:0] i_pm0,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [PM_W-1:0] i_pm2,
    input  logic [PM_W-1:0] i_pm3,
    output logic [1:0]      o_idx,
    output logic [PM_W-1:0] o_min
);
    logic            w_lo_sel;
    logic            w_hi_sel;
    logic            w_pick_hi;
    logic [PM_W-1:0] w_lo_val;
    logic [PM_W-1:0] w_hi_val;

    // Strict less-than at every level keeps the lower index on equal metrics.
    assign w_lo_sel  = i_pm1 < i_pm0;
    assign w_lo_val  = w_lo_sel ? i_pm1 : i_pm0;
    assign w_hi_sel  = i_pm3 < i_pm2;
    assign w_hi_val  = w_hi_sel ? i_pm3 : i_pm2;
    assign w_pick_hi = w_hi_val < w_lo_val;

    assign o_idx = w_pick_hi ? {1'b1, w_hi_sel} : {1'b0, w_lo_sel};
    assign o_min = w_pick_hi ? w_hi_val : w_lo_val;
endmodule

// File: rtl/vit_decision_out.sv
// Viterbi output stage: picks the best state per step, emits the oldest survivor
// bit through a small FIFO, flushes the winning survivor at frame end.
module vit_decision_out
    import vit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NORM_THR   = 64
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            sym_valid,
    input  logic            sym_last,
    input  logic [PM_W-1:0] pm_0,
    input  logic [PM_W-1:0] pm_1,
    input  logic [PM_W-1:0] pm_2,
    input  logic [PM_W-1:0] pm_3,
    input  logic [SP_W-1:0] sp_0,
    input  logic [SP_W-1:0] sp_1,
    input  logic [SP_W-1:0] sp_2,
    input  logic [SP_W-1:0] sp_3,
    output logic            in_ready,
    output logic            dec_bit,
    output logic            dec_valid,
    input  logic            out_ready,
    output logic [1:0]      best_state,
    output logic [PM_W-1:0] pm_min,
    output logic            norm_req,
    output logic            frame_done,
    output logic            overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FILL_W = $clog2(SP_W + 1);
    localparam int IDX_W  = $clog2(SP_W);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SP_W);
    localparam logic [PM_W-1:0]   THR      = PM_W'(NORM_THR);

    fsm_t                  r_state;
    logic [FILL_W-1:0]     r_fill_cnt;
    logic [FILL_W-1:0]     r_rem;
    logic [SP_W-1:0]       r_flush_reg;
    logic [FIFO_DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [1:0]            r_best_state;
    logic [PM_W-1:0]       r_pm_min;
    logic                  r_norm_req;
    logic                  r_frame_done;
    logic                  r_overflow;

    logic [1:0]        w_best_idx;
    logic [PM_W-1:0]   w_best_pm;
    logic [SP_W-1:0]   w_sp_best;
    logic              w_full;
    logic              w_accept;
    logic [FILL_W-1:0] w_fill_next;
    logic [FILL_W-1:0] w_rem_init;
    logic [IDX_W-1:0]  w_rem_idx;
    logic              w_run_push;
    logic              w_flush_push;
    logic              w_push;
    logic              w_push_bit;
    logic              w_pop;

    vit_min4 u_min4 (
        .i_pm0 (pm_0),
        .i_pm1 (pm_1),
        .i_pm2 (pm_2),
        .i_pm3 (pm_3),
        .o_idx (w_best_idx),
        .o_min (w_best_pm)
    );

    always_comb begin
        w_sp_best = sp_0;
        case (w_best_idx)
            2'd1:    w_sp_best = sp_1;
            2'd2:    w_sp_best = sp_2;
            2'd3:    w_sp_best = sp_3;
            default: w_sp_best = sp_0;
        endcase
    end

    assign w_full      = (r_count == FULL_CNT);
    assign in_ready    = (r_state == ST_RUN) && !w_full;
    assign w_accept    = sym_valid && in_ready;
    assign w_fill_next = (r_fill_cnt == FILL_MAX) ? FILL_MAX : r_fill_cnt + 1'b1;
    // Once the survivor window is full, every step retires its oldest bit; the
    // flush then owes the remaining SP_W-1 positions of the winning survivor.
    assign w_rem_init  = (w_fill_next < FILL_MAX) ? w_fill_next : FILL_MAX - 1'b1;
    assign w_rem_idx   = IDX_W'(r_rem - 1'b1);

    assign w_run_push   = w_accept && (w_fill_next == FILL_MAX);
    assign w_flush_push = (r_state == ST_FLUSH) && !w_full;
    assign w_push       = w_run_push || w_flush_push;
    assign w_push_bit   = (r_state == ST_FLUSH) ? r_flush_reg[w_rem_idx] : w_sp_best[SP_W-1];
    assign w_pop        = out_ready && (r_count != '0);

    assign dec_valid  = (r_count != '0);
    assign dec_bit    = r_mem[r_rd_ptr];
    assign best_state = r_best_state;
    assign pm_min     = r_pm_min;
    assign norm_req   = r_norm_req;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_bit;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_fill_cnt   <= '0;
            r_rem        <= '0;
            r_flush_reg  <= '0;
            r_best_state <= '0;
            r_pm_min     <= '0;
            r_norm_req   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (sym_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_best_state <= w_best_idx;
                r_pm_min     <= w_best_pm;
                r_norm_req   <= (w_best_pm >= THR);
                r_fill_cnt   <= w_fill_next;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_accept && sym_last) begin
                        r_flush_reg <= w_sp_best;
                        r_rem       <= w_rem_init;
                        if (w_rem_init != '0) begin
                            r_state <= ST_FLUSH;
                        end else begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!w_full) begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == FILL_W'(1)) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_fill_cnt <= '0;
                    r_state    <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_vit_decision_out.sv
// Randomized bench for vit_decision_out against a frame-level register-exchange
// reference: best-state choice per step and the decoded bit stream per frame.
module tb_vit_decision_out;
    import vit_pkg::*;

    localparam int THR = 64;
    localparam logic [14:0] RST_OUTS = {1'b1, 14'b0};

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            sym_valid = 1'b0;
    logic            sym_last = 1'b0;
    logic [PM_W-1:0] pm_0 = '0, pm_1 = '0, pm_2 = '0, pm_3 = '0;
    logic [SP_W-1:0] sp_0 = '0, sp_1 = '0, sp_2 = '0, sp_3 = '0;
    logic            out_ready = 1'b1;
    logic            in_ready, dec_bit, dec_valid, norm_req, frame_done, overflow;
    logic [1:0]      best_state;
    logic [PM_W-1:0] pm_min;
    logic [14:0]     outs;

    int n_vec = 0;
    int n_err = 0;

    bit              got_q[$];
    bit              exp_q[$];
    logic [SP_W-1:0] frame_sp[$];
    logic [1:0]      exp_bs;
    logic [PM_W-1:0] exp_pm;
    logic            exp_norm;

    vit_decision_out #(.FIFO_DEPTH(4), .NORM_THR(THR)) dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_last(sym_last),
        .pm_0(pm_0), .pm_1(pm_1), .pm_2(pm_2), .pm_3(pm_3),
        .sp_0(sp_0), .sp_1(sp_1), .sp_2(sp_2), .sp_3(sp_3),
        .in_ready(in_ready), .dec_bit(dec_bit), .dec_valid(dec_valid),
        .out_ready(out_ready), .best_state(best_state), .pm_min(pm_min),
        .norm_req(norm_req), .frame_done(frame_done), .overflow(overflow)
    );

    assign outs = {in_ready, dec_valid, dec_bit, best_state, pm_min, norm_req, frame_done, overflow};

    always #5 clk = ~clk;

    // Every bit that leaves the block, in departure order.
    always @(negedge clk) begin
        if (rst && dec_valid && out_ready) got_q.push_back(dec_bit);
    end

    // Register-exchange view of a frame: after SP_W steps fill the window each
    // step retires its survivor's oldest bit; at frame end the winning survivor
    // of the last step supplies the rest, oldest first, one bit per step overall.
    function automatic void build_expected();
        int n = frame_sp.size();
        int k;
        exp_q.delete();
        for (int i = 0; i < n; i++) if (i + 1 >= SP_W) exp_q.push_back(frame_sp[i][SP_W-1]);
        k = (n < SP_W) ? n : SP_W - 1;
        for (int j = k - 1; j >= 0; j--) exp_q.push_back(frame_sp[n-1][j]);
    endfunction

    function automatic logic [31:0] packq(input bit q[$]);
        logic [31:0] v = '0;
        for (int i = 0; i < q.size() && i < 32; i++) v = {v[30:0], q[i]};
        return v;
    endfunction

    function automatic bit bits_differ();
        bit bad = (got_q.size() != exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad = 1;
        return bad;
    endfunction

    task automatic new_frame();
        got_q.delete();
        frame_sp.delete();
    endtask

    // Called aligned just after a rising edge; returns just after the accepting edge.
    task automatic step(input logic [3:0][PM_W-1:0] p, input logic [3:0][SP_W-1:0] s, input logic last);
        int waited = 0;
        int bi = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL step_wait: in_ready=%b after %0d cycles, required 1", in_ready, waited);
            return;
        end
        pm_0 = p[0]; pm_1 = p[1]; pm_2 = p[2]; pm_3 = p[3];
        sp_0 = s[0]; sp_1 = s[1]; sp_2 = s[2]; sp_3 = s[3];
        sym_valid = 1'b1; sym_last = last;
        @(posedge clk); #1;
        sym_valid = 1'b0; sym_last = 1'b0;
        for (int i = 1; i < 4; i++) if (p[i] < p[bi]) bi = i;
        exp_bs   = bi[1:0];
        exp_pm   = p[bi];
        exp_norm = (p[bi] >= THR);
        frame_sp.push_back(s[bi]);
    endtask

    task automatic rand_step(input logic last);
        logic [3:0][PM_W-1:0] p;
        logic [3:0][SP_W-1:0] s;
        for (int i = 0; i < 4; i++) begin
            p[i] = PM_W'($urandom_range(0, 127));
            s[i] = SP_W'($urandom);
        end
        step(p, s, last);
    endtask

    task automatic wait_idle(output int pulses, output int rdy_hi, output bit tmo);
        int cyc = 0;
        bit seen = 0;
        pulses = 0; rdy_hi = 0;
        while (!(seen && !dec_valid) && cyc < 300) begin
            if (frame_done) begin pulses++; seen = 1; end
            else if (!seen && in_ready) rdy_hi++;
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) begin
            if (frame_done) pulses++;
            @(posedge clk); #1;
        end
        tmo = !seen;
    endtask

    task automatic check_frame(input string name);
        int pulses, rdy_hi;
        bit tmo;
        wait_idle(pulses, rdy_hi, tmo);
        build_expected();
        n_vec++;
        if (tmo || pulses != 1) begin
            n_err++;
            $display("FAIL %s_done: frame_done pulses=%0d timeout=%0d, required 1 pulse", name, pulses, tmo);
        end
        n_vec++;
        if (bits_differ()) begin
            n_err++;
            $display("FAIL %s_bits: got %0d bits %h, required %0d bits %h", name,
                     got_q.size(), packq(got_q), exp_q.size(), packq(exp_q));
        end
        n_vec++;
        if (rdy_hi != 0) begin
            n_err++;
            $display("FAIL %s_flush_rdy: in_ready high %0d cycles before frame_done, required 0", name, rdy_hi);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_vec++;
        if (outs !== RST_OUTS) begin
            n_err++; $display("FAIL reset_held: outputs=%h required %h", outs, RST_OUTS);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (outs !== RST_OUTS) begin
            n_err++; $display("FAIL reset_idle: outputs=%h required %h", outs, RST_OUTS);
        end
    endtask

    task automatic test_min_tie();
        logic [3:0][PM_W-1:0] p;
        logic [3:0][SP_W-1:0] s;
        new_frame();
        for (int i = 0; i < 4; i++) s[i] = SP_W'($urandom);
        p[0] = 7'd5; p[1] = 7'd3; p[2] = 7'd3; p[3] = 7'd9;
        step(p, s, 1'b0);
        n_vec++;
        if ({best_state, pm_min, norm_req} !== {2'd1, 7'd3, 1'b0}) begin
            n_err++; $display("FAIL min_tie: best=%0d pm=%0d norm=%b, required 1 3 0", best_state, pm_min, norm_req);
        end
        p = {4{7'd70}};
        step(p, s, 1'b0);
        n_vec++;
        if ({best_state, pm_min, norm_req} !== {2'd0, 7'd70, 1'b1}) begin
            n_err++; $display("FAIL min_all_eq: best=%0d pm=%0d norm=%b, required 0 70 1", best_state, pm_min, norm_req);
        end
        rand_step(1'b1);
        check_frame("min_tie");
    endtask

    task automatic test_fill_latency();
        logic [3:0][PM_W-1:0] p;
        logic [3:0][SP_W-1:0] s;
        logic [7:0] pat = 8'b1011_0010;
        new_frame();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                p[j] = PM_W'($urandom_range(1, 127));
                s[j] = SP_W'($urandom);
            end
            p[2] = '0;
            s[2][SP_W-1] = pat[7-i];
            step(p, s, (i == 7));
            n_vec++;
            if (i < 7 && dec_valid !== 1'b0) begin
                n_err++; $display("FAIL fill_early: step %0d dec_valid=%b required 0", i + 1, dec_valid);
            end else if (i == 7 && {dec_valid, dec_bit} !== {1'b1, frame_sp[7][SP_W-1]}) begin
                n_err++; $display("FAIL fill_first: valid=%b bit=%b required 1 %b", dec_valid, dec_bit, frame_sp[7][SP_W-1]);
            end
        end
        check_frame("fill");
    endtask

    task automatic test_short_flush();
        logic [3:0][PM_W-1:0] p;
        logic [3:0][SP_W-1:0] s;
        int w;
        new_frame();
        rand_step(1'b0);
        rand_step(1'b0);
        w = $urandom_range(0, 3);
        for (int j = 0; j < 4; j++) begin
            p[j] = PM_W'($urandom_range(1, 127));
            s[j] = SP_W'($urandom);
        end
        p[w] = '0;
        s[w] = 8'b0000_0101;
        step(p, s, 1'b1);
        check_frame("short");
        n_vec++;
        if (dut.r_fill_cnt !== '0) begin
            n_err++; $display("FAIL short_fill_clr: fill_cnt=%0d required 0", dut.r_fill_cnt);
        end
    endtask

    task automatic test_long_frame();
        new_frame();
        for (int i = 0; i < 10; i++) begin
            rand_step(i == 9);
            n_vec++;
            if ({best_state, pm_min, norm_req} !== {exp_bs, exp_pm, exp_norm}) begin
                n_err++; $display("FAIL long_min: step %0d got %0d/%0d/%b required %0d/%0d/%b", i + 1,
                                  best_state, pm_min, norm_req, exp_bs, exp_pm, exp_norm);
            end
        end
        check_frame("long");
    endtask

    task automatic test_backpressure();
        new_frame();
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) rand_step(1'b0);
        n_vec++;
        if ({in_ready, dec_valid, overflow} !== 3'b010) begin
            n_err++; $display("FAIL bp_full: in_ready/valid/ovf=%b required 010", {in_ready, dec_valid, overflow});
        end
        pm_0 = PM_W'($urandom); sym_valid = 1'b1;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++; $display("FAIL bp_overflow: overflow=%b required 1", overflow);
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        n_vec++;
        if (got_q.size() != 4 || got_q[0] !== frame_sp[7][SP_W-1] || got_q[1] !== frame_sp[8][SP_W-1]
            || got_q[2] !== frame_sp[9][SP_W-1] || got_q[3] !== frame_sp[10][SP_W-1]) begin
            n_err++; $display("FAIL bp_drain: got %0d bits %h, required 4 bits %b%b%b%b", got_q.size(), packq(got_q),
                              frame_sp[7][SP_W-1], frame_sp[8][SP_W-1], frame_sp[9][SP_W-1], frame_sp[10][SP_W-1]);
        end
        rand_step(1'b1);
        check_frame("bp");
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++; $display("FAIL bp_sticky: overflow=%b required 1", overflow);
        end
    endtask

    task automatic test_reset_mid_flush();
        int seen_done = 0;
        new_frame();
        for (int i = 0; i < 10; i++) rand_step(i == 9);
        repeat (3) @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL rmf_in_flush: in_ready=%b required 0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (outs !== RST_OUTS) begin
            n_err++; $display("FAIL rmf_async: outputs=%h required %h", outs, RST_OUTS);
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (frame_done) seen_done++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (frame_done) seen_done++;
        end
        n_vec++;
        if (seen_done != 0 || outs !== RST_OUTS) begin
            n_err++; $display("FAIL rmf_after: frame_done seen %0d outputs=%h, required 0 and %h", seen_done, outs, RST_OUTS);
        end
        new_frame();
        for (int i = 0; i < 3; i++) rand_step(i == 2);
        check_frame("rmf_next");
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 6; f++) begin
            new_frame();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                rand_step(i == len - 1);
                n_vec++;
                if ({best_state, pm_min, norm_req} !== {exp_bs, exp_pm, exp_norm}) begin
                    n_err++; $display("FAIL rand_min: frame %0d step %0d got %0d/%0d/%b required %0d/%0d/%b", f, i,
                                      best_state, pm_min, norm_req, exp_bs, exp_pm, exp_norm);
                end
            end
            check_frame("rand");
        end
    endtask

    initial begin
        test_reset();
        test_min_tie();
        test_fill_latency();
        test_short_flush();
        test_long_frame();
        test_backpressure();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vit_decision_out.md
Name: vit_decision_out

Overview:
- Output stage of the 4-state (K=3, rate-1/2) register-exchange Viterbi decoder. Sits directly downstream of the four ACS/memory cells.
- Each symbol it takes the four registered path metrics and survivor registers and picks the best state (minimum metric). It then emits the decided bit from the oldest survivor position.
- Buffers decoded bits in a small FIFO for downstream backpressure, flushes the best survivor at end of frame, and raises a normalization request for the metric path.

Parameters:
- PM_W, 7, path-metric width.
- SP_W, 8, survivor register width (traceback depth); bit SP_W-1 is oldest, bit 0 newest.
- FIFO_DEPTH, 4, decoded-bit output FIFO entries (power of 2, at least 2).
- NORM_THR, 64, metric level at or above which norm_req asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sym_valid  in  1  ACS outputs updated this cycle (one trellis step).
- sym_last  in  1  qualifies sym_valid; this step is the last of the frame.
- pm_0..pm_3  in  PM_W each  path metrics of states 0..3.
- sp_0..sp_3  in  SP_W each  survivor registers of states 0..3.
- in_ready  out  1  block can accept a step.
- dec_bit  out  1  decoded bit, FIFO head.
- dec_valid  out  1  dec_bit valid.
- out_ready  in  1  downstream accepts dec_bit.
- best_state  out  2  registered index of the minimum-metric state.
- pm_min  out  PM_W  registered minimum metric.
- norm_req  out  1  registered; pm_min >= NORM_THR.
- frame_done  out  1  one-cycle pulse after the last bit of a frame enters the FIFO.
- overflow  out  1  sticky; a step arrived while in_ready=0.

Behaviour:
- Reset (rst=0): every output is 0 except in_ready, which is 1. FIFO is empty, fill_cnt=0, FSM=RUN, overflow=0. Reset asynchronously aborts a flush in progress.
- Min select is combinational over pm_0..pm_3, unsigned. On ties the lowest state index wins.
- A step is accepted when sym_valid=1 and in_ready=1.
  - On accept: best_state, pm_min and norm_req register the same cycle.
- in_ready = (FSM==RUN) and (FIFO count <= FIFO_DEPTH-1).
- A step with sym_valid=1 and in_ready=0 is dropped and sets overflow. overflow clears only on reset.
- fill_cnt: on accept, fill_cnt increments and saturates at SP_W.
  - When the post-increment value equals SP_W (including while already saturated), push sp_best[SP_W-1] into the FIFO.
  - Latency: the bit is visible at dec_valid the cycle after accept when the FIFO was empty.
- FSM states:
  - RUN: normal operation. An accept with sym_last=1 does three things:
    - latches sp_best into flush_reg;
    - sets rem = post-increment fill_cnt if that value is < SP_W, else SP_W-1;
    - goes to FLUSH if rem > 0, otherwise to DONE.
  - FLUSH: each cycle the FIFO is not full, push flush_reg[rem-1] and decrement rem. When rem reaches 0 after a push, go to DONE. No accepts in FLUSH.
  - DONE: pulse frame_done for one cycle, clear fill_cnt, return to RUN.
- Bits emitted per frame equal the steps accepted in that frame, oldest first.
- FIFO: simultaneous push and pop on a full FIFO is allowed (count unchanged). A pop on empty is ignored. dec_bit is held stable while dec_valid=1 and out_ready=0.
- Arithmetic: all comparisons are unsigned PM_W bits with no wrap handling; normalization is the ACS owner's job, driven by norm_req.

Decomposition:
- Shared package vit_pkg holds: PM_W, SP_W, N_STATES=4, the state-index type (2 bits), and the FSM encoding (RUN=0, FLUSH=1, DONE=2).
- Natural sub-module: vit_min4, the combinational 4-way minimum with lowest-index tie-break, outputting index and value. It is reusable by the ACS normalization logic.
- The FIFO stays inline.

Test Plan:
- Min/tie: pm = 5,3,3,9 on one step -> best_state=1, pm_min=3 next cycle. Then pm = 70,70,70,70 -> best_state=0, norm_req=1.
- Fill latency: 8 steps, best state always 2, with sp_2 bit7 = 1,0,1,1,0,0,1,0 per step -> no dec_valid for steps 1-7; step 8 yields dec_bit=0 one cycle later.
- Short-frame flush: 3 steps, the last with sym_last=1, flush_reg=8'b0000_0101 -> 3 bits emitted 1,0,1 (bits 2,1,0), frame_done pulses once, fill_cnt returns to 0.
- Long frame: 10 steps with sym_last on step 10 -> exactly 10 bits total (3 in RUN, 7 in FLUSH), order checked against a reference model; in_ready=0 throughout FLUSH.
- Backpressure: out_ready=0 with continuous steps -> FIFO fills to 4, in_ready drops. A further step sets overflow=1. Raising out_ready drains 4 bits in order.
- Reset mid-flush: rst=0 during FLUSH with 4 bits remaining -> all outputs go to reset values immediately, no frame_done. After release, a new 3-step frame decodes correctly.
